// File: rtl/imgmem_tile_arbiter_pkg.sv
// Shared definitions for the image-RAM port-A arbiter and tile-fill engine:
// screen geometry, board geometry defaults, field widths and FSM encoding.
package imgmem_tile_arbiter_pkg;

  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H         = 480;

  localparam int TILE_DEF         = 16;
  localparam int BOARD_W_DEF      = 10;
  localparam int BOARD_H_DEF      = 20;
  localparam int ORIGIN_X_DEF     = 240;
  localparam int ORIGIN_Y_DEF     = 80;
  localparam int STARVE_LIMIT_DEF = 8;

  localparam int COLOR_W          = 8;
  localparam int ADDR_W           = 19;
  localparam int TX_W             = 4;
  localparam int TY_W             = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/imgmem_tile_arbiter_tile_addr_gen.sv
// tile_addr_gen: computes the top-left pixel address of a board tile and
// walks the tile in raster order, one pixel per enabled cycle.
//   clock, iRST_n : clock / async active-low reset
//   load          : capture base address of tile (tx,ty), clear px/py
//   adv           : step to the next pixel of the tile
//   tx, ty        : tile column / row
//   cur_addr      : address of the current pixel
//   last          : current pixel is the bottom-right one of the tile
module tile_addr_gen
  import imgmem_tile_arbiter_pkg::*;
#(
  parameter int TILE     = TILE_DEF,
  parameter int ORIGIN_X = ORIGIN_X_DEF,
  parameter int ORIGIN_Y = ORIGIN_Y_DEF,
  parameter int STRIDE   = SCREEN_W
) (
  input  logic              clock,
  input  logic              iRST_n,
  input  logic              load,
  input  logic              adv,
  input  logic [TX_W-1:0]   tx,
  input  logic [TY_W-1:0]   ty,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  localparam int                PW       = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [PW-1:0]     P_MAX    = PW'(TILE - 1);
  // Jump from the right edge of one tile row to the left edge of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE - (TILE - 1));

  logic [PW-1:0]     px, py;
  logic [ADDR_W-1:0] row, col, base;

  // Whole computation stays in ADDR_W bits; the largest on-screen address
  // fits, so nothing is lost.
  assign row  = ADDR_W'(ORIGIN_Y) + ADDR_W'(ty) * ADDR_W'(TILE);
  assign col  = ADDR_W'(ORIGIN_X) + ADDR_W'(tx) * ADDR_W'(TILE);
  assign base = row * ADDR_W'(STRIDE) + col;

  assign last = (px == P_MAX) && (py == P_MAX);

  always_ff @(posedge clock or negedge iRST_n) begin
    if (!iRST_n) begin
      px       <= '0;
      py       <= '0;
      cur_addr <= '0;
    end else if (load) begin
      px       <= '0;
      py       <= '0;
      cur_addr <= base;
    end else if (adv) begin
      if (px == P_MAX) begin
        px       <= '0;
        py       <= py + 1'b1;
        cur_addr <= cur_addr + ROW_STEP;
      end else begin
        px       <= px + 1'b1;
        cur_addr <= cur_addr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imgmem_tile_arbiter.sv
// imgmem_tile_arbiter: owns image-RAM port A and shares it between the
// processor load/store path (priority) and a tile-fill engine that paints
// one TILE x TILE board cell with a solid colour, one pixel per cycle.
// The engine is forced a slot after STARVE_LIMIT consecutive stalls.
//   clock, iRST_n           : clock (RAM runs on ~clock) / async active-low reset
//   proc_req/addr/data/wren : processor access; proc_q returns RAM data
//   proc_stall              : processor lost this cycle, hold request
//   fill_req/tx/ty/color    : tile fill request (sampled only when idle)
//   fill_ack/done/err       : one-cycle status pulses; fill_busy while filling
//   mem_addr/data/wren/q    : RAM port-A pins
module imgmem_tile_arbiter
  import imgmem_tile_arbiter_pkg::*;
#(
  parameter int TILE         = TILE_DEF,
  parameter int BOARD_W      = BOARD_W_DEF,
  parameter int BOARD_H      = BOARD_H_DEF,
  parameter int ORIGIN_X     = ORIGIN_X_DEF,
  parameter int ORIGIN_Y     = ORIGIN_Y_DEF,
  parameter int SCREEN_W     = imgmem_tile_arbiter_pkg::SCREEN_W,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               clock,
  input  logic               iRST_n,
  input  logic               proc_req,
  input  logic [ADDR_W-1:0]  proc_addr,
  input  logic [COLOR_W-1:0] proc_data,
  input  logic               proc_wren,
  output logic [COLOR_W-1:0] proc_q,
  output logic               proc_stall,
  input  logic               fill_req,
  input  logic [TX_W-1:0]    fill_tx,
  input  logic [TY_W-1:0]    fill_ty,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               fill_ack,
  output logic               fill_busy,
  output logic               fill_done,
  output logic               fill_err,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wren,
  input  logic [COLOR_W-1:0] mem_q
);

  localparam int               SW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]    SLIMIT  = SW'(STARVE_LIMIT);

  fill_state_t        state_q, state_d;
  logic [COLOR_W-1:0] color_q;
  logic [SW-1:0]      starve_q;
  logic [ADDR_W-1:0]  cur_addr;
  logic               last_px;
  logic               eng_grant;
  logic               load;
  logic               ack_d, err_d;
  logic               in_range;

  assign in_range  = (int'(fill_tx) < BOARD_W) && (int'(fill_ty) < BOARD_H);

  // Processor wins unless the engine has been starved long enough.
  assign eng_grant = (state_q == ST_FILL) && (!proc_req || starve_q == SLIMIT);

  assign proc_stall = proc_req && eng_grant;
  assign proc_q     = mem_q;

  always_comb begin
    mem_addr = proc_addr;
    mem_data = proc_data;
    mem_wren = proc_req && proc_wren;
    if (eng_grant) begin
      mem_addr = cur_addr;
      mem_data = color_q;
      mem_wren = 1'b1;
    end
  end

  tile_addr_gen #(
    .TILE     (TILE),
    .ORIGIN_X (ORIGIN_X),
    .ORIGIN_Y (ORIGIN_Y),
    .STRIDE   (SCREEN_W)
  ) u_addr_gen (
    .clock    (clock),
    .iRST_n   (iRST_n),
    .load     (load),
    .adv      (eng_grant),
    .tx       (fill_tx),
    .ty       (fill_ty),
    .cur_addr (cur_addr),
    .last     (last_px)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fill_req) begin
          if (in_range) begin
            load    = 1'b1;
            ack_d   = 1'b1;
            state_d = ST_FILL;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (eng_grant && last_px) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= ST_IDLE;
      color_q   <= '0;
      fill_ack  <= 1'b0;
      fill_err  <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (load) color_q <= fill_color;
      fill_ack  <= ack_d;
      fill_err  <= err_d;
      fill_busy <= (state_d == ST_FILL);
      // Registered off the DONE state, so it lands the cycle after DONE.
      fill_done <= (state_q == ST_DONE);
    end
  end

  always_ff @(posedge clock or negedge iRST_n) begin
    if (!iRST_n) begin
      starve_q <= '0;
    end else if (state_q != ST_FILL || eng_grant) begin
      starve_q <= '0;
    end else if (starve_q != SLIMIT) begin
      starve_q <= starve_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_imgmem_tile_arbiter.sv
// Self-checking bench for imgmem_tile_arbiter: a RAM model on the inverted
// clock, a write log, and a picture-level model of what the screen should
// hold after each fill.
module tb_imgmem_tile_arbiter;

  localparam int T    = 16;
  localparam int OX   = 240;
  localparam int OY   = 80;
  localparam int W    = 640;
  localparam int NPIX = 640 * 480;
  localparam int PRE  = 1000;

  logic        clock = 1'b0;
  logic        iRST_n = 1'b0;
  logic        proc_req = 1'b0;
  logic [18:0] proc_addr = '0;
  logic [7:0]  proc_data = '0;
  logic        proc_wren = 1'b0;
  logic [7:0]  proc_q;
  logic        proc_stall;
  logic        fill_req = 1'b0;
  logic [3:0]  fill_tx = '0;
  logic [4:0]  fill_ty = '0;
  logic [7:0]  fill_color = '0;
  logic        fill_ack, fill_busy, fill_done, fill_err;
  logic [18:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  mem_q = '0;

  imgmem_tile_arbiter dut (
    .clock(clock), .iRST_n(iRST_n),
    .proc_req(proc_req), .proc_addr(proc_addr), .proc_data(proc_data),
    .proc_wren(proc_wren), .proc_q(proc_q), .proc_stall(proc_stall),
    .fill_req(fill_req), .fill_tx(fill_tx), .fill_ty(fill_ty),
    .fill_color(fill_color), .fill_ack(fill_ack), .fill_busy(fill_busy),
    .fill_done(fill_done), .fill_err(fill_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  logic [7:0]  ram [0:NPIX-1];
  logic [7:0]  img [0:NPIX-1];
  logic [18:0] wa[$];
  logic [7:0]  wd[$];
  int wr_n = 0, done_n = 0, cyc = 0, ack_cyc = 0, done_cyc = 0;
  int checks = 0, errors = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // RAM port A on ~clock: write, and read-before-write data out.
  always @(negedge clock) begin
    if (mem_wren) begin
      ram[mem_addr] <= mem_data;
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wr_n <= wr_n + 1;
    end
    mem_q <= ram[mem_addr];
    if (fill_ack) ack_cyc <= cyc;
    if (fill_done) begin
      done_cyc <= cyc;
      done_n   <= done_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pix_addr(input int tx, input int ty, input int p);
    return (OY + ty*T + p/T) * W + OX + tx*T + (p % T);
  endfunction

  function automatic int img_diffs();
    int n = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== img[i]) n++;
    return n;
  endfunction

  task automatic paint(input int tx, input int ty, input logic [7:0] col, input int n);
    for (int p = 0; p < n; p++) img[pix_addr(tx, ty, p)] = col;
  endtask

  task automatic start_fill(input int tx, input int ty, input logic [7:0] col);
    @(posedge clock); #1;
    fill_req = 1'b1; fill_tx = 4'(tx); fill_ty = 5'(ty); fill_color = col;
    @(posedge clock); #1;
    fill_req = 1'b0;
  endtask

  // mode 0: no processor traffic; 1: reads held high; 2: random reads
  task automatic run_fill(input int tx, input int ty, input logic [7:0] col,
                          input int mode, input string tag);
    int stall_bad = 0, addr_bad = 0, read_bad = 0, seq_bad = 0, k = 0;
    bit got_done = 0, granted;
    wa.delete(); wd.delete();
    start_fill(tx, ty, col);
    check({tag, " ack"}, fill_ack, 1);
    check({tag, " busy"}, fill_busy, 1);
    for (int i = 0; i < 4000; i++) begin
      proc_wren = 1'b0;
      proc_addr = 19'(PRE);
      case (mode)
        1:       proc_req = 1'b1;
        2:       proc_req = ($urandom_range(0, 2) == 0);
        default: proc_req = 1'b0;
      endcase
      @(negedge clock);
      if (fill_done) begin got_done = 1; break; end
      if (mode == 1 && fill_busy) begin
        if (proc_stall !== ((k % 9) == 8)) stall_bad++;
        k++;
      end
      granted = proc_req && !proc_stall;
      if (granted && mem_addr !== proc_addr) addr_bad++;
      #1;
      if (granted && proc_q !== 8'hA5) read_bad++;
      @(posedge clock); #1;
    end
    proc_req = 1'b0;
    proc_addr = '0;
    #2;
    check({tag, " done seen"}, 32'(got_done), 1);
    check({tag, " write count"}, wa.size(), T*T);
    for (int p = 0; p < wa.size() && p < T*T; p++)
      if (wa[p] !== 19'(pix_addr(tx, ty, p)) || wd[p] !== col) seq_bad++;
    check({tag, " pixel sequence"}, seq_bad, 0);
    paint(tx, ty, col, T*T);
    check({tag, " image"}, img_diffs(), 0);
    if (mode == 0) check({tag, " ack-to-done"}, done_cyc - ack_cyc, T*T + 1);
    if (mode == 1) begin
      check({tag, " ack-to-done"}, done_cyc - ack_cyc, 9*T*T + 1);
      check({tag, " stall pattern"}, stall_bad, 0);
    end
    if (mode != 0) begin
      check({tag, " proc addr"}, addr_bad, 0);
      check({tag, " proc read"}, read_bad, 0);
    end
  endtask

  task automatic bad_req(input int tx, input int ty, input string tag);
    int n0 = wr_n;
    @(posedge clock); #1;
    fill_req = 1'b1; fill_tx = 4'(tx); fill_ty = 5'(ty); fill_color = 8'hEE;
    @(posedge clock); #1;
    fill_req = 1'b0;
    check({tag, " err"}, fill_err, 1);
    check({tag, " ack"}, fill_ack, 0);
    check({tag, " busy"}, fill_busy, 0);
    repeat (3) @(posedge clock);
    #1;
    check({tag, " err pulse"}, fill_err, 0);
    check({tag, " writes"}, wr_n - n0, 0);
    check({tag, " busy after"}, fill_busy, 0);
  endtask

  initial begin
    int rtx, rty, d0;
    logic [7:0] rc;
    for (int i = 0; i < NPIX; i++) begin ram[i] = 8'h00; img[i] = 8'h00; end

    #12;
    check("reset ack", fill_ack, 0);
    check("reset busy", fill_busy, 0);
    check("reset done", fill_done, 0);
    check("reset err", fill_err, 0);
    check("reset wren", mem_wren, 0);
    check("reset addr", mem_addr, 0);
    check("reset stall", proc_stall, 0);
    @(posedge clock); #1;
    iRST_n = 1'b1;

    // processor preload outside every tile
    @(posedge clock); #1;
    proc_req = 1'b1; proc_wren = 1'b1; proc_addr = 19'(PRE); proc_data = 8'hA5;
    @(negedge clock);
    check("preload stall", proc_stall, 0);
    @(posedge clock); #1;
    proc_req = 1'b0; proc_wren = 1'b0; proc_addr = '0; proc_data = '0;
    img[PRE] = 8'hA5;
    check("preload ram", ram[PRE], 8'hA5);

    // first tile, idle port
    run_fill(0, 0, 8'h1C, 0, "tile00");
    check("tile00 first addr", wa[0], 51440);
    check("tile00 16th addr", wa[15], 51455);
    check("tile00 17th addr", wa[16], 52080);

    // last tile, boundary
    run_fill(9, 19, 8'h5B, 0, "tile919");
    check("tile919 last addr", wa[T*T-1], 255759);

    bad_req(10, 3, "tx10");
    bad_req(2, 20, "ty20");

    // processor hogging the port, engine forced a slot every ninth cycle
    run_fill(4, 7, 8'h33, 1, "starve");

    // random tiles with random interleaved processor reads
    for (int r = 0; r < 3; r++) begin
      rtx = $urandom_range(0, 9);
      rty = $urandom_range(0, 19);
      rc  = 8'($urandom_range(1, 255));
      run_fill(rtx, rty, rc, 2, "random");
    end

    // async reset after 100 engine writes
    wa.delete(); wd.delete();
    start_fill(3, 5, 8'h77);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock); #2;
      if (wa.size() >= 100) break;
    end
    check("abort writes before reset", wa.size(), 100);
    iRST_n = 1'b0;
    #1;
    check("abort wren", mem_wren, 0);
    check("abort addr", mem_addr, 0);
    check("abort data", mem_data, 0);
    check("abort stall", proc_stall, 0);
    check("abort busy", fill_busy, 0);
    d0 = done_n;
    repeat (4) @(posedge clock);
    #1;
    check("abort no more writes", wa.size(), 100);
    check("abort no done", done_n - d0, 0);
    paint(3, 5, 8'h77, 100);
    check("abort image", img_diffs(), 0);
    iRST_n = 1'b1;
    run_fill(6, 12, 8'h9D, 0, "after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imgmem_tile_arbiter.md
Name: imgmem_tile_arbiter

Overview:
- Owns port A of the image RAM (640x480, 8-bit colour index, address = y*640 + x).
- Shares that port between two requesters:
  - the processor's load/store path, which has priority;
  - a hardware tile-fill engine that paints one TILE x TILE board cell with a solid colour, one pixel per cycle.
- Sits between the processor's imgmem port and the imgram port-A pins, so tile repaints no longer take processor instructions.

Parameters:
- TILE, 16, tile edge in pixels
- BOARD_W, 10, board width in tiles
- BOARD_H, 20, board height in tiles
- ORIGIN_X, 240, pixel x of tile (0,0)
- ORIGIN_Y, 80, pixel y of tile (0,0)
- SCREEN_W, 640, pixels per row (address stride)
- STARVE_LIMIT, 8, consecutive engine stall cycles before the engine is forced a slot

Ports:
- clock  in  1  system clock; the RAM is clocked on ~clock
- iRST_n  in  1  asynchronous, active-low reset
- proc_req  in  1  processor requests port A this cycle (read or write)
- proc_addr  in  19  processor address
- proc_data  in  8  processor write data
- proc_wren  in  1  processor write enable (qualified by proc_req)
- proc_q  out  8  read data to processor (pass-through of mem_q)
- proc_stall  out  1  processor access not granted this cycle; hold request
- fill_req  in  1  start a tile fill
- fill_tx  in  4  tile column
- fill_ty  in  5  tile row
- fill_color  in  8  colour index
- fill_ack  out  1  one-cycle pulse: request accepted
- fill_busy  out  1  engine active
- fill_done  out  1  one-cycle pulse: last pixel written
- fill_err  out  1  one-cycle pulse: request rejected (coordinate out of range)
- mem_addr  out  19  RAM port-A address
- mem_data  out  8  RAM port-A write data
- mem_wren  out  1  RAM port-A write enable
- mem_q  in  8  RAM port-A read data

Behaviour:
- Reset values (async on iRST_n low): state IDLE; counters, address and colour registers 0; fill_ack, fill_busy, fill_done, fill_err all 0; starve count 0.
  - Combinational outputs go to their idle values: mem_wren=0, mem_addr=0, mem_data=0, proc_stall=0.
  - Reset mid-fill abandons the fill immediately; no further writes; no fill_done.
- FSM states:
  - IDLE: if fill_req is high at a clock edge:
    - coordinates in range (fill_tx<BOARD_W and fill_ty<BOARD_H): latch colour, compute base = (ORIGIN_Y+ty*TILE)*SCREEN_W + ORIGIN_X + tx*TILE, pulse fill_ack, go FILL.
    - otherwise: pulse fill_err, stay IDLE.
  - FILL: fill_busy=1. In each engine-granted cycle:
    - write the colour at cur_addr;
    - advance px;
    - when px wraps from TILE-1 to 0: add SCREEN_W-(TILE-1) to cur_addr and advance py; otherwise add 1 to cur_addr.
    - The write of (px,py)=(TILE-1,TILE-1) moves the FSM to DONE.
  - DONE: pulse fill_done for one cycle, fill_busy=0, return to IDLE. fill_req is not sampled in DONE, so the minimum spacing between fills is 1 cycle.
- Request handshake:
  - fill_req is level-sampled only in IDLE.
  - Held high, it starts a new fill after each DONE.
  - Inputs are don't-care outside IDLE.
- Arbitration (combinational, per cycle):
  - Engine grant = FILL and (not proc_req or starve_cnt==STARVE_LIMIT); otherwise the processor is granted.
  - Processor granted: mem_addr=proc_addr, mem_data=proc_data, mem_wren=proc_wren.
  - Engine granted: mem_addr=cur_addr, mem_data=colour, mem_wren=1.
  - proc_stall = proc_req and engine grant.
- Starve counter:
  - increments each FILL cycle where proc_req denies the engine;
  - resets to 0 on any engine grant or outside FILL;
  - saturates at STARVE_LIMIT.
- Latency:
  - no address/data pipeline inside the block;
  - RAM read data returns per the RAM's inverted-clock timing;
  - proc_q = mem_q at all times.
- Fill length: exactly TILE*TILE engine writes, all inside the tile rectangle, none outside.
- Fill duration: with no processor traffic, ack-to-done = TILE*TILE+1 cycles.
- Width rules:
  - base computed in 19 bits; maximum address is less than 640*480, so no overflow;
  - px/py counters are clog2(TILE) bits.

Decomposition:
- Shared package: SCREEN_W/SCREEN_H, board geometry defaults, colour-index width, FSM state encoding (IDLE, FILL, DONE).
- One natural sub-module: tile_addr_gen (base computation plus px/py raster walk with an advance enable). Arbitration and the FSM stay in the top.

Test Plan:
- Idle fill, no proc traffic: fill (tx=0,ty=0,colour=8'h1C):
  - fill_ack at the accept edge;
  - 256 writes, first at 51440 (80*640+240), 16th at 51455, 17th at 52080;
  - fill_done 257 cycles after ack; model RAM holds 8'h1C in exactly that 16x16 region.
- Last tile, bounds: fill (tx=9,ty=19):
  - last write at (80+319)*640+240+159 = 255759;
  - no writes outside the rectangle.
- Out of range: fill_tx=10 or fill_ty=20 -> fill_err pulse, no fill_ack, zero writes, fill_busy stays 0.
- Processor priority and starvation:
  - proc_req held high during FILL -> processor granted 8 consecutive cycles with proc_stall=0;
  - 9th cycle: engine writes and proc_stall=1;
  - pattern repeats; total engine writes are still 256.
- Interleaved proc reads: a processor read of an address outside the tile during FILL -> proc_q returns the preloaded value; the engine pixel sequence is unchanged and merely delayed.
- Async reset mid-fill: assert iRST_n low after 100 engine writes:
  - outputs go to their idle values immediately, no fill_done, no further writes;
  - after release, a new fill completes normally.
